mem_line_arbiter: RTL and testbench

//  Sits directly downstream of the I-/D-cache miss engines and shares one 64-bit line-wide main-memory port between them.

---
 rtl/mem_line_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_line_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares one line-wide main-memory port between the I-cache and D-cache miss engines.
// Latency: request -> done is 3 cycles minimum (IDLE grant, one BUSY cycle, RESP pulse); BUSY lasts until m_ready or timeout.
// Backpressure: requests are level-held until done; one transaction at a time, memory stalls by withholding m_ready.
//
// Ports:
//   clk, reset_n                    clock and asynchronous active-low reset
//   i_req_rd/i_addr -> i_rdata/i_done               I-cache line read channel
//   d_req_rd/d_req_wr/d_addr/d_wdata -> d_rdata/d_done   D-cache line read / write-back channel
//   m_read/m_write/m_addr/m_wdata <- m_rdata/m_ready     shared memory port
//   err_timeout                     one-cycle pulse when a transaction is aborted by the wait limit
//   i_grant_cnt/d_grant_cnt/conflict_cnt   saturating statistics counters
module mem_line_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 64,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req_rd,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req_rd,
    input  logic              d_req_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_done,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Wait counter just wide enough to hold TIMEOUT; a single bit when no limit is configured.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;     // 1 = D side won the most recent conflict
    logic                side_d_q, side_d_d;     // owner of the in-flight transaction (1 = D)
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-3:0]   addr_q, addr_d;         // line address only; word offset is dropped
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
    logic [TW-1:0]       wait_q, wait_d;
    logic                to_q, to_d;
    logic [CNT_W-1:0]    i_grant_q, i_grant_d;
    logic [CNT_W-1:0]    d_grant_q, d_grant_d;
    logic [CNT_W-1:0]    conflict_q, conflict_d;

    logic i_pend, d_pend, both_pend, grant_d, timeout_hit;
    logic unused_addr_lsbs;

    // The word offset inside a line never reaches memory.
    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign i_pend    = i_req_rd;
    assign d_pend    = d_req_rd | d_req_wr;
    assign both_pend = i_pend & d_pend;
    // D wins when alone, or in a conflict when I was granted last.
    assign grant_d   = d_pend & (~i_pend | ~last_d_q);
    // wait_q counts completed BUSY cycles, so the limit trips in the TIMEOUT-th BUSY cycle.
    assign timeout_hit = (TIMEOUT > 0) && (wait_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        side_d_d   = side_d_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        wait_d     = wait_q;
        to_d       = 1'b0;
        i_grant_d  = i_grant_q;
        d_grant_d  = d_grant_q;
        conflict_d = conflict_q;

        case (state_q)
            ST_IDLE: begin
                if (both_pend) begin
                    conflict_d = sat_inc(conflict_q);
                end
                if (i_pend || d_pend) begin
                    side_d_d = grant_d;
                    // A simultaneous read+write from D is a write-back.
                    op_wr_d  = grant_d & d_req_wr;
                    addr_d   = grant_d ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
                    wdata_d  = grant_d ? d_wdata : '0;
                    wait_d   = '0;
                    if (both_pend) begin
                        last_d_d = grant_d;
                    end
                    if (grant_d) begin
                        d_grant_d = sat_inc(d_grant_q);
                    end else begin
                        i_grant_d = sat_inc(i_grant_q);
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (m_ready) begin
                    if (!op_wr_q) begin
                        if (side_d_q) begin
                            d_rdata_d = m_rdata;
                        end else begin
                            i_rdata_d = m_rdata;
                        end
                    end
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    to_d    = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            last_d_q   <= 1'b0;
            side_d_q   <= 1'b0;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            wait_q     <= '0;
            to_q       <= 1'b0;
            i_grant_q  <= '0;
            d_grant_q  <= '0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            side_d_q   <= side_d_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            wait_q     <= wait_d;
            to_q       <= to_d;
            i_grant_q  <= i_grant_d;
            d_grant_q  <= d_grant_d;
            conflict_q <= conflict_d;
        end
    end

    // Strobes and done pulses decode straight from registered state, so an
    // asynchronous reset clears them without waiting for a clock.
    assign m_read       = (state_q == ST_BUSY) & ~op_wr_q;
    assign m_write      = (state_q == ST_BUSY) &  op_wr_q;
    assign m_addr       = {addr_q, 2'b00};
    assign m_wdata      = wdata_q;
    assign i_done       = (state_q == ST_RESP) & ~side_d_q;
    assign d_done       = (state_q == ST_RESP) &  side_d_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign err_timeout  = to_q;
    assign i_grant_cnt  = i_grant_q;
    assign d_grant_cnt  = d_grant_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
`timescale 1ns/1ps
module tb_mem_line_arbiter;

    localparam int AW = 16;
    localparam int LW = 64;
    localparam int CW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          i_req_rd = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_rdata;
    logic          i_done;
    logic          d_req_rd = 1'b0;
    logic          d_req_wr = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_done;
    logic          m_read, m_write;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic [LW-1:0] m_rdata = '0;
    logic          m_ready = 1'b0;
    logic          err_timeout;
    logic [CW-1:0] i_grant_cnt, d_grant_cnt, conflict_cnt;

    always #5 clk = ~clk;

    mem_line_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req_rd(i_req_rd), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req_rd(d_req_rd), .d_req_wr(d_req_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .err_timeout(err_timeout),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
    );

    typedef struct {
        bit          side_d;
        bit          rd;
        bit          to;
        logic [63:0] rdata;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [63:0] wdata;
        int          delay;   // BUSY cycles before m_ready; -1 = never
        logic [63:0] rdata;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit side_d, input bit rd, input bit to, input logic [63:0] rdata);
        exp_t e;
        e.side_d = side_d; e.rd = rd; e.to = to; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic push_mem(input bit wr, input logic [15:0] addr, input logic [63:0] wdata,
                            input int delay, input logic [63:0] rdata);
        mem_t m;
        m.wr = wr; m.addr = addr; m.wdata = wdata; m.delay = delay; m.rdata = rdata;
        mem_q.push_back(m);
    endtask

    // Memory model: checks each new transaction against mem_q and answers after its delay.
    mem_t cur;
    bit   active = 0;
    int   cnt = 0;
    int   last_busy = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            active  = 0;
            m_ready = 1'b0;
        end else begin
            m_ready = 1'b0;
            if ((m_read || m_write) && !active) begin
                active = 1;
                cnt    = 0;
                if (mem_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL mem_unexpected: m_read=%0b m_write=%0b addr=%h with nothing expected",
                             m_read, m_write, m_addr);
                    cur.wr = 0; cur.addr = 0; cur.wdata = 0; cur.delay = 0; cur.rdata = 0;
                end else begin
                    cur = mem_q.pop_front();
                    check("mem_is_write", {63'd0, m_write}, {63'd0, cur.wr});
                    check("mem_addr", {48'd0, m_addr}, {48'd0, cur.addr});
                    if (cur.wr) check("mem_wdata", m_wdata, cur.wdata);
                end
            end
            if (active) begin
                if (!(m_read || m_write)) begin
                    active    = 0;
                    last_busy = cnt;
                end else begin
                    if (cur.delay >= 0 && cnt == cur.delay) begin
                        m_ready = 1'b1;
                        m_rdata = cur.rdata;
                    end
                    cnt++;
                end
            end
        end
    end

    // Completion monitor: every done pulse must match the next expected response.
    exp_t e_mon;
    always @(negedge clk) begin
        if (reset_n) begin
            if (i_done || d_done) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done_unexpected: i_done=%0b d_done=%0b with nothing expected", i_done, d_done);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("done_side", {62'd0, i_done, d_done}, e_mon.side_d ? 64'd1 : 64'd2);
                    check("err_timeout", {63'd0, err_timeout}, {63'd0, e_mon.to});
                    if (e_mon.rd) begin
                        if (e_mon.side_d) check("d_rdata", d_rdata, e_mon.rdata);
                        else              check("i_rdata", i_rdata, e_mon.rdata);
                    end
                end
            end else if (err_timeout) begin
                n_tests++; n_fail++;
                $display("FAIL err_timeout_alone: got 1 expected 0 without done");
            end
        end
    end

    // Issue one request, wait (bounded) for its done, then drop it. Entered and left #1 after posedge.
    // lat numbers the request cycle as 1 and reports the cycle in which done is seen.
    task automatic run_req(input bit side_d, input bit wr, input bit rd_too, input logic [15:0] addr,
                           input logic [63:0] wdata, output int lat);
        bit seen = 0;
        lat = 1;
        if (side_d) begin
            d_addr = addr; d_wdata = wdata; d_req_wr = wr; d_req_rd = !wr || rd_too;
        end else begin
            i_addr = addr; i_req_rd = 1'b1;
        end
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (side_d ? d_done : i_done) seen = 1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL done_wait: got no done expected done within 100 cycles (side_d=%0b)", side_d);
        end
        @(posedge clk); #1;
        if (side_d) begin d_req_rd = 1'b0; d_req_wr = 1'b0; end
        else i_req_rd = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_i_done"},   {63'd0, i_done}, 64'd0);
        check({tag, "_d_done"},   {63'd0, d_done}, 64'd0);
        check({tag, "_m_read"},   {63'd0, m_read}, 64'd0);
        check({tag, "_m_write"},  {63'd0, m_write}, 64'd0);
        check({tag, "_err_to"},   {63'd0, err_timeout}, 64'd0);
        check({tag, "_m_addr"},   {48'd0, m_addr}, 64'd0);
        check({tag, "_m_wdata"},  m_wdata, 64'd0);
        check({tag, "_i_rdata"},  i_rdata, 64'd0);
        check({tag, "_d_rdata"},  d_rdata, 64'd0);
        check({tag, "_i_grant"},  {60'd0, i_grant_cnt}, 64'd0);
        check({tag, "_d_grant"},  {60'd0, d_grant_cnt}, 64'd0);
        check({tag, "_conflict"}, {60'd0, conflict_cnt}, 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_req_rd = 0; d_req_rd = 0; d_req_wr = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        exp_q.delete(); mem_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_cnt(input string tag, input int ig, input int dg, input int cf);
        check({tag, "_i_grant_cnt"},  {60'd0, i_grant_cnt},  64'(ig));
        check({tag, "_d_grant_cnt"},  {60'd0, d_grant_cnt},  64'(dg));
        check({tag, "_conflict_cnt"}, {60'd0, conflict_cnt}, 64'(cf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat2, ndone;

        // Reset state, sampled while reset is still held.
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_quiet("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Lone I read, m_ready one cycle after m_read rises; offset bits dropped.
        push_mem(0, 16'h0120, 64'd0, 1, 64'h1111_2222_3333_4444);
        push_exp(0, 1, 0, 64'h1111_2222_3333_4444);
        run_req(0, 0, 0, 16'h0123, 64'd0, lat);
        check("lone_i_latency", 64'(lat), 64'd4);
        check("lone_i_busy_cycles", 64'(last_busy), 64'd2);
        check_cnt("lone_i", 1, 0, 0);

        // D read answered in the first BUSY cycle: minimum latency 3.
        push_mem(0, 16'hABCC, 64'd0, 0, 64'hDEAD_BEEF_0000_0001);
        push_exp(1, 1, 0, 64'hDEAD_BEEF_0000_0001);
        run_req(1, 0, 0, 16'hABCF, 64'd0, lat);
        check("min_latency", 64'(lat), 64'd3);
        check("i_rdata_held", i_rdata, 64'h1111_2222_3333_4444);
        check_cnt("lone_d", 1, 1, 0);

        // Conflict after reset: D write-back (rd+wr together) first, then I read.
        do_reset();
        push_mem(1, 16'h0200, 64'hCAFE_F00D_1234_5678, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        push_mem(0, 16'h0300, 64'd0, 0, 64'h0BAD_0BAD_0BAD_0BAD);
        push_exp(1, 0, 0, 64'd0);
        push_exp(0, 1, 0, 64'h0BAD_0BAD_0BAD_0BAD);
        fork
            run_req(1, 1, 1, 16'h0201, 64'hCAFE_F00D_1234_5678, lat);
            run_req(0, 0, 0, 16'h0302, 64'd0, lat2);
        join
        check_cnt("conflict", 1, 1, 1);
        check("write_leaves_d_rdata", d_rdata, 64'd0);

        // Both requesting continuously for four transactions: D, I, D, I.
        do_reset();
        push_mem(0, 16'h1000, 64'd0, 0, 64'hA0A0_A0A0_A0A0_A0A0);
        push_mem(0, 16'h2000, 64'd0, 1, 64'hA1A1_A1A1_A1A1_A1A1);
        push_mem(0, 16'h1000, 64'd0, 0, 64'hA2A2_A2A2_A2A2_A2A2);
        push_mem(0, 16'h2000, 64'd0, 2, 64'hA3A3_A3A3_A3A3_A3A3);
        push_exp(1, 1, 0, 64'hA0A0_A0A0_A0A0_A0A0);
        push_exp(0, 1, 0, 64'hA1A1_A1A1_A1A1_A1A1);
        push_exp(1, 1, 0, 64'hA2A2_A2A2_A2A2_A2A2);
        push_exp(0, 1, 0, 64'hA3A3_A3A3_A3A3_A3A3);
        i_addr = 16'h2000; d_addr = 16'h1000; i_req_rd = 1'b1; d_req_rd = 1'b1;
        ndone = 0;
        for (int k = 0; k < 200 && ndone < 4; k++) begin
            @(negedge clk);
            if (i_done || d_done) ndone++;
        end
        check("rr_done_count", 64'(ndone), 64'd4);
        @(posedge clk); #1;
        i_req_rd = 1'b0; d_req_rd = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_cnt("round_robin", 2, 2, 4);
        check("rr_d_rdata", d_rdata, 64'hA2A2_A2A2_A2A2_A2A2);
        check("rr_i_rdata", i_rdata, 64'hA3A3_A3A3_A3A3_A3A3);

        // Timeout: one good D read, then one that memory never answers.
        do_reset();
        push_mem(0, 16'h0040, 64'd0, 0, 64'h7777_6666_5555_4444);
        push_exp(1, 1, 0, 64'h7777_6666_5555_4444);
        run_req(1, 0, 0, 16'h0040, 64'd0, lat);
        push_mem(0, 16'h0044, 64'd0, -1, 64'h9999_9999_9999_9999);
        push_exp(1, 1, 1, 64'h7777_6666_5555_4444);
        run_req(1, 0, 0, 16'h0044, 64'd0, lat);
        check("timeout_busy_cycles", 64'(last_busy), 64'd8);
        check("timeout_latency", 64'(lat), 64'd10);
        check_cnt("timeout", 0, 2, 0);

        // Asynchronous reset in the middle of BUSY.
        push_mem(0, 16'h0080, 64'd0, -1, 64'd0);
        d_addr = 16'h0080; d_req_rd = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("busy_before_reset", {63'd0, m_read}, 64'd1);
        reset_n = 1'b0;
        #1 check_quiet("mid_busy_reset");
        d_req_rd = 1'b0;
        exp_q.delete(); mem_q.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        push_mem(0, 16'h0554, 64'd0, 1, 64'h0123_4567_89AB_CDEF);
        push_exp(0, 1, 0, 64'h0123_4567_89AB_CDEF);
        run_req(0, 0, 0, 16'h0555, 64'd0, lat);
        check_cnt("after_reset", 1, 0, 0);

        // Saturation of the 4-bit grant counter at all-ones.
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            push_mem(0, 16'h0700, 64'd0, 0, 64'(k));
            push_exp(0, 1, 0, 64'(k));
            run_req(0, 0, 0, 16'h0700, 64'd0, lat);
            if (k == 15) check("grant_at_max", {60'd0, i_grant_cnt}, 64'd15);
        end
        check("grant_saturated", {60'd0, i_grant_cnt}, 64'd15);
        check("sat_last_rdata", i_rdata, 64'd17);

        repeat (3) @(posedge clk); #1;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("mem_q_drained", 64'(mem_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
